dcache_flush_ctrl: RTL and testbench

Hardware flush sequencer and memory-port arbiter for the 2-way, 16-set write-back data cache. On request it walks every cache entry, writes each valid-and-dirty 256-bit line back to data memory over the line handshake, and clears its dirty bit. When idle it is transparent: it passes the dcache controller's miss/write-back traffic straight through to data memory. It sits between the dcache controller, the dcache SRAM maintenance port and Data_Memory, and replaces end-of-run software flushing.

---
 rtl/dcache_flush_ctrl.sv | 118 +++++++++++
 tb/tb_dcache_flush_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: write-back flush sequencer and Data_Memory port arbiter for the 2-way 16-set dcache.
// Idle it passes dcache controller traffic through; on request it writes back every valid dirty line.
module dcache_flush_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_req_i,
    output logic         flush_busy_o,
    output logic         flush_done_o,
    output logic         cpu_stall_o,
    output logic [5:0]   flushed_cnt_o,
    output logic [3:0]   sram_idx_o,
    output logic         sram_way_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    output logic         sram_we_o,
    output logic [24:0]  sram_tag_o,
    input  logic         dc_mem_enable_i,
    input  logic         dc_mem_write_i,
    input  logic [31:0]  dc_mem_addr_i,
    input  logic [255:0] dc_mem_data_i,
    output logic         dc_mem_ack_o,
    output logic [255:0] dc_mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i
);
    typedef enum logic [2:0] {IDLE, SCAN, WB, CLEAN, DONE} state_t;
    state_t       state_q, state_d;
    logic         pend_q, pend_d;
    logic [4:0]   e_q, e_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] data_q, data_d;
    logic [24:0]  tag_q, tag_d;
    logic         idle;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            e_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;
        case (state_q)
            // an in-flight dcache transfer owns the port until it drops enable
            IDLE: begin
                if (pend_q && !dc_mem_enable_i) begin
                    state_d = SCAN;
                    pend_d  = 1'b0;
                    e_d     = '0;
                    cnt_d   = '0;
                end else if (flush_req_i) begin
                    pend_d = 1'b1;
                end
            end
            SCAN: begin
                if (sram_tag_i[24] && sram_tag_i[23]) begin
                    state_d = WB;
                    addr_d  = {sram_tag_i[22:0], e_q[3:0], 5'b0};
                    data_d  = sram_data_i;
                    tag_d   = sram_tag_i;
                end else if (e_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    e_d = e_q + 5'd1;
                end
            end
            WB: state_d = mem_ack_i ? CLEAN : WB;
            CLEAN: begin
                cnt_d   = cnt_q + 6'd1;
                state_d = (e_q == 5'd31) ? DONE : SCAN;
                e_d     = (e_q == 5'd31) ? e_q : e_q + 5'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign idle          = state_q == IDLE;
    assign flush_busy_o  = pend_q || !idle;
    assign cpu_stall_o   = flush_busy_o;
    assign flush_done_o  = state_q == DONE;
    assign flushed_cnt_o = cnt_q;
    assign sram_way_o    = e_q[4];
    assign sram_idx_o    = e_q[3:0];
    assign sram_we_o     = state_q == CLEAN;
    assign sram_tag_o    = {tag_q[24], 1'b0, tag_q[22:0]};
    assign mem_enable_o  = idle ? dc_mem_enable_i : state_q == WB;
    assign mem_write_o   = idle ? dc_mem_write_i : state_q == WB;
    assign mem_addr_o    = idle ? dc_mem_addr_i : addr_q;
    assign mem_data_o    = idle ? dc_mem_data_i : data_q;
    assign dc_mem_ack_o  = idle && mem_ack_i;
    assign dc_mem_data_o = mem_data_i;
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb_dcache_flush_ctrl: scoreboard bench with an SRAM/memory model; expected write-backs, tags and
// done timing come from walking the cache contents in entry order.
module tb_dcache_flush_ctrl;
    logic         clk_i, rst_i, flush_req_i;
    logic         flush_busy_o, flush_done_o, cpu_stall_o;
    logic [5:0]   flushed_cnt_o;
    logic [3:0]   sram_idx_o;
    logic         sram_way_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_we_o;
    logic [24:0]  sram_tag_o;
    logic         dc_mem_enable_i, dc_mem_write_i;
    logic [31:0]  dc_mem_addr_i;
    logic [255:0] dc_mem_data_i;
    logic         dc_mem_ack_o;
    logic [255:0] dc_mem_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    dcache_flush_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i),
        .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .cpu_stall_o(cpu_stall_o),
        .flushed_cnt_o(flushed_cnt_o), .sram_idx_o(sram_idx_o), .sram_way_o(sram_way_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_we_o(sram_we_o),
        .sram_tag_o(sram_tag_o), .dc_mem_enable_i(dc_mem_enable_i), .dc_mem_write_i(dc_mem_write_i),
        .dc_mem_addr_i(dc_mem_addr_i), .dc_mem_data_i(dc_mem_data_i), .dc_mem_ack_o(dc_mem_ack_o),
        .dc_mem_data_o(dc_mem_data_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
        logic [24:0]  tag;
        logic         way;
        logic [3:0]   idx;
    } wr_t;
    typedef struct {
        int         cyc;
        logic [5:0] cnt;
    } dn_t;

    logic [24:0]  tag_mem [2][16];
    logic [255:0] dat_mem [2][16];
    logic [24:0]  fin_tag [2][16];
    wr_t exp_q[$];
    dn_t done_q[$];
    int  lat_q[$];
    int  nchk = 0, nerr = 0, cyc = 0, ndone = 0, nwr = 0;

    assign sram_tag_i  = tag_mem[sram_way_o][sram_idx_o];
    assign sram_data_i = dat_mem[sram_way_o][sram_idx_o];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // SRAM tag write port: strobe sampled mid-low phase, applied at the following edge
    initial begin
        logic wv, ww;
        logic [3:0] wi;
        logic [24:0] wt;
        forever begin
            @(negedge clk_i);
            #2;
            wv = sram_we_o; ww = sram_way_o; wi = sram_idx_o; wt = sram_tag_o;
            @(posedge clk_i);
            if (wv && !rst_i) tag_mem[ww][wi] = wt;
        end
    end

    // Data_Memory responder: ack after a latency taken from lat_q, one-cycle pulse
    initial begin
        int rcnt, rlat;
        rcnt = 0; rlat = 3;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                rcnt = 0;
            end else if (mem_enable_o === 1'b1 && !rst_i) begin
                if (rcnt == 0) rlat = (lat_q.size() != 0) ? lat_q.pop_front() : 3;
                rcnt++;
                if (rcnt >= rlat) begin
                    mem_ack_i = 1'b1;
                    mem_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // monitor: pops the scoreboard on every flush write-back, tag clear and done pulse
    initial begin
        wr_t cur;
        dn_t dn;
        bit  tag_pend;
        tag_pend = 0;
        forever begin
            @(negedge clk_i);
            #2;
            chk("stall_eq_busy", cpu_stall_o, flush_busy_o);
            if (mem_ack_i && mem_enable_o && !dc_mem_ack_o) begin
                nwr++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_addr", mem_addr_o, 32'hx);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wb_addr", mem_addr_o, cur.addr);
                    chk("wb_data", mem_data_o, cur.data);
                    chk("wb_write", mem_write_o, 1'b1);
                    tag_pend = 1;
                end
            end
            if (sram_we_o) begin
                chk("clean_expected", tag_pend, 1'b1);
                chk("clean_tag", sram_tag_o, cur.tag);
                chk("clean_way_idx", {sram_way_o, sram_idx_o}, {cur.way, cur.idx});
                tag_pend = 0;
            end
            if (flush_done_o) begin
                ndone++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", flush_done_o, 1'b0);
                end else begin
                    dn = done_q.pop_front();
                    chk("done_cycle", cyc, dn.cyc);
                    chk("flushed_cnt", flushed_cnt_o, dn.cnt);
                    chk("wb_outstanding", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic clear_mem();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
                tag_mem[w][s] = '0;
                dat_mem[w][s] = '0;
            end
    endtask

    task automatic rnd_mem();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
                tag_mem[w][s] = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 23'($urandom)};
                dat_mem[w][s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
    endtask

    // reference: every valid dirty entry in way-major order, each costing its latency plus one cycle
    task automatic plan(input int lo, input int hi, output int extra, output int n);
        logic [24:0] t;
        int l;
        extra = 0;
        n = 0;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
                t = tag_mem[w][s];
                fin_tag[w][s] = t;
                if (t[24] && t[23]) begin
                    l = $urandom_range(hi, lo);
                    lat_q.push_back(l);
                    exp_q.push_back('{{t[22:0], s[3:0], 5'b0}, dat_mem[w][s], {2'b10, t[22:0]}, w[0], s[3:0]});
                    fin_tag[w][s][23] = 1'b0;
                    extra += l + 1;
                    n++;
                end
            end
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && ndone == d0; i++) @(negedge clk_i);
        chk("done_seen", ndone != d0, 1'b1);
        repeat (3) @(negedge clk_i);
        #3;
        chk("busy_after_done", flush_busy_o, 1'b0);
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++)
                chk($sformatf("final_tag_w%0d_s%0d", w, s), tag_mem[w][s], fin_tag[w][s]);
    endtask

    task automatic flush(input int lo, input int hi, input bit extra_req);
        int extra, n, c, d0;
        @(negedge clk_i);
        plan(lo, hi, extra, n);
        c = cyc;
        d0 = ndone;
        done_q.push_back('{c + 34 + extra, 6'(n)});
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        #3;
        chk("busy_after_req", flush_busy_o, 1'b1);
        if (extra_req) begin
            repeat (5) @(negedge clk_i);
            flush_req_i = 1'b1;
            @(negedge clk_i);
            flush_req_i = 1'b0;
        end
        wait_done(d0);
    endtask

    initial begin
        int extra, n, d0, n0;
        logic [31:0] a;
        rst_i = 1'b1;
        flush_req_i = 1'b0;
        dc_mem_enable_i = 1'b0;
        dc_mem_write_i = 1'b0;
        dc_mem_addr_i = '0;
        dc_mem_data_i = '0;
        clear_mem();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #3;
        chk("reset_busy", flush_busy_o, 1'b0);
        chk("reset_cnt", flushed_cnt_o, 6'd0);

        // clean cache: 32 scan cycles, no write-back
        flush(1, 1, 0);

        // one dirty line, set 3 way 1, memory ack after 10 cycles
        clear_mem();
        tag_mem[1][3] = {2'b11, 23'h10};
        dat_mem[1][3] = {8{32'hECFAECFA}};
        flush(10, 10, 0);

        // async reset while a flush is pending behind a dcache write
        @(negedge clk_i);
        a = 32'hDEAD_BEE0;
        dc_mem_enable_i = 1'b1;
        dc_mem_write_i = 1'b1;
        dc_mem_addr_i = a;
        dc_mem_data_i = {8{$urandom}};
        lat_q.push_back(40);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        #3;
        chk("pend_busy", flush_busy_o, 1'b1);
        chk("pend_cnt_held", flushed_cnt_o, 6'd1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_busy", flush_busy_o, 1'b0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_done", flush_done_o, 1'b0);
        chk("rst_cnt", flushed_cnt_o, 6'd0);
        chk("rst_we", sram_we_o, 1'b0);
        chk("rst_sram_tag", sram_tag_o, 25'd0);
        chk("rst_mem_en", mem_enable_o, 1'b1);
        chk("rst_mem_wr", mem_write_o, 1'b1);
        chk("rst_mem_addr", mem_addr_o, a);
        chk("rst_mem_data", mem_data_o, dc_mem_data_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        dc_mem_enable_i = 1'b0;
        lat_q.delete();
        repeat (3) @(negedge clk_i);
        #3;
        chk("rst_pend_cleared", flush_busy_o, 1'b0);

        // valid-clean, dirty-invalid and valid-dirty entries
        clear_mem();
        tag_mem[0][0] = {2'b10, 23'h1234};
        tag_mem[0][1] = {2'b01, 23'h2345};
        tag_mem[0][2] = {2'b11, 23'h3456};
        dat_mem[0][2] = {8{$urandom}};
        flush(1, 4, 0);

        // flush requested while a dcache read miss is in flight
        rnd_mem();
        @(negedge clk_i);
        dc_mem_enable_i = 1'b1;
        dc_mem_write_i = 1'b0;
        dc_mem_addr_i = $urandom;
        lat_q.push_back(6);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        #3;
        chk("miss_busy", flush_busy_o, 1'b1);
        chk("miss_mem_en", mem_enable_o, 1'b1);
        chk("miss_mem_addr", mem_addr_o, dc_mem_addr_i);
        for (int i = 0; i < 50 && !dc_mem_ack_o; i++) begin
            @(negedge clk_i);
            #3;
        end
        chk("miss_ack_passed", dc_mem_ack_o, 1'b1);
        chk("miss_rdata", dc_mem_data_o, mem_data_i);
        plan(1, 5, extra, n);
        d0 = ndone;
        @(negedge clk_i);
        dc_mem_enable_i = 1'b0;
        done_q.push_back('{cyc + 33 + extra, 6'(n)});
        wait_done(d0);

        // random cache contents and latencies, some with a request repeated mid-flush
        for (int i = 0; i < 6; i++) begin
            rnd_mem();
            flush(1, 6, i[0]);
        end

        // reset during the write-back of the second of two dirty lines
        clear_mem();
        tag_mem[0][4] = {2'b11, 23'($urandom)};
        tag_mem[1][9] = {2'b11, 23'($urandom)};
        dat_mem[0][4] = {8{$urandom}};
        dat_mem[1][9] = {8{$urandom}};
        @(negedge clk_i);
        plan(1, 1, extra, n);
        lat_q.delete();
        lat_q.push_back(2);
        lat_q.push_back(60);
        n0 = nwr;
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        for (int i = 0; i < 200 && nwr == n0; i++) @(negedge clk_i);
        chk("first_wb_seen", nwr, n0 + 1);
        for (int i = 0; i < 200 && !mem_enable_o; i++) begin
            @(negedge clk_i);
            #3;
        end
        chk("second_wb_started", mem_enable_o, 1'b1);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_mem_en", mem_enable_o, 1'b0);
        chk("abort_busy", flush_busy_o, 1'b0);
        exp_q.delete();
        done_q.delete();
        lat_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("abort_first_clean", tag_mem[0][4][23], 1'b0);
        chk("abort_second_dirty", tag_mem[1][9][23], 1'b1);
        chk("abort_idle", flush_busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #1000000;
        nerr++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $fatal(1, "watchdog");
    end
endmodule
